// File: rtl/counter_pkg.sv
// Shared definitions for the SimpleProcessor counter family.
//   counter_state_t        : two-state run control {IDLE, RUN}
//   COUNTER_WIDTH_DEFAULT  : default counter/load width in bits
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } counter_state_t;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/decr_nb.sv
// Combinational WIDTH-bit decrementer built as a ripple borrow chain.
// Ports:
//   value  : operand
//   dec    : value - 1 (modulo 2^WIDTH)
//   is_one : value == 1, used for terminal-step detection
module decr_nb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] dec,
  output logic             is_one
);

  // borrow[i] is the borrow into bit i; subtracting one injects a borrow at bit 0.
  logic [WIDTH-1:0] borrow;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign dec[i] = value[i] ^ borrow[i];
  end

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_borrow
    assign borrow[i+1] = ~value[i] & borrow[i];
  end

  assign is_one = value[0] & ~(|value[WIDTH-1:1]);

endmodule

// File: rtl/counter_nb_down.sv
// Loadable down counter/timer. Decrements once per enabled cycle while
// running; on the terminal step (count 1 -> next) it pulses o_done and
// either stops at 0 (one-shot) or reloads the start value (auto-reload).
// Configuration macro: COUNTER_DN_RELOAD_EN adds the i_mode port and the
// auto-reload behaviour; without it the block is always one-shot.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_load   : load strobe (priority over stepping)
//   i_input  : start value captured on load
//   i_mode   : 0 one-shot, 1 auto-reload, captured on load (macro only)
//   i_en     : count enable, one step per cycle in RUN
//   o_count  : current count (registered)
//   o_busy   : high while running (registered state)
//   o_zero   : count == 0, decoded from the count register
//   o_done   : one-cycle completion pulse (registered)
module counter_nb_down
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_input,
`ifdef COUNTER_DN_RELOAD_EN
  input  logic             i_mode,
`endif
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_zero,
  output logic             o_done
);

  counter_state_t   state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] count_dec;
  logic             count_is_one;
  logic             done, done_nxt;
`ifdef COUNTER_DN_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             mode, mode_nxt;
`endif

  decr_nb #(.WIDTH(WIDTH)) u_decr (
    .value  (count),
    .dec    (count_dec),
    .is_one (count_is_one)
  );

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    done_nxt   = 1'b0;
`ifdef COUNTER_DN_RELOAD_EN
    reload_nxt = reload;
    mode_nxt   = mode;
`endif
    if (i_load) begin
      count_nxt  = i_input;
`ifdef COUNTER_DN_RELOAD_EN
      reload_nxt = i_input;
      mode_nxt   = i_mode;
`endif
      state_nxt  = (i_input != '0) ? RUN : IDLE;
    end else if (state == RUN && i_en) begin
      if (count_is_one) begin
        done_nxt = 1'b1;
`ifdef COUNTER_DN_RELOAD_EN
        if (mode) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
`else
        count_nxt = '0;
        state_nxt = IDLE;
`endif
      end else begin
        count_nxt = count_dec;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      count  <= '0;
      done   <= 1'b0;
`ifdef COUNTER_DN_RELOAD_EN
      reload <= '0;
      mode   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done   <= done_nxt;
`ifdef COUNTER_DN_RELOAD_EN
      reload <= reload_nxt;
      mode   <= mode_nxt;
`endif
    end
  end

  assign o_count = count;
  assign o_busy  = (state == RUN);
  assign o_zero  = (count == '0);
  assign o_done  = done;

endmodule

// File: tb/tb_counter_nb_down.sv
// Self-checking bench for counter_nb_down (WIDTH=4): table-driven
// sequences, hand-written corner sequences and randomized stimulus
// compared against a reference model. Honours COUNTER_DN_RELOAD_EN.
module tb_counter_nb_down;

  localparam int unsigned W = 4;
`ifdef COUNTER_DN_RELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, load, mode, en;
  logic [W-1:0] din;
  logic [W-1:0] count;
  logic         busy, zero, done;

  int errors = 0;
  int checks = 0;

  // Reference model: post-edge values derived from the behavioural rules.
  int m_cnt = 0, m_rel = 0;
  bit m_mode = 0, m_done = 0;

  counter_nb_down #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (load),
    .i_input (din),
`ifdef COUNTER_DN_RELOAD_EN
    .i_mode  (mode),
`endif
    .i_en    (en),
    .o_count (count),
    .o_busy  (busy),
    .o_zero  (zero),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, load;
    bit [3:0] din;
    bit       mode, en;
    bit [3:0] cnt;
    bit       busy, zero, done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit l, int d, bit m, bit e,
                              int c, bit b, bit z, bit dn);
    vec_t v;
    v.rst = r; v.load = l; v.din = 4'(d); v.mode = m; v.en = e;
    v.cnt = 4'(c); v.busy = b; v.zero = z; v.done = dn;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit l, input int d, input bit m, input bit e);
    m_done = 0;
    if (r) begin
      m_cnt = 0; m_rel = 0; m_mode = 0;
    end else if (l) begin
      m_cnt = d; m_rel = d; m_mode = RELOAD_EN ? m : 1'b0;
    end else if (m_cnt != 0 && e) begin
      if (m_cnt == 1) begin
        m_cnt  = m_mode ? m_rel : 0;
        m_done = 1;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later.
  task automatic cycle(input bit r, input bit l, input int d, input bit m, input bit e);
    @(negedge clk);
    rst = r; load = l; din = W'(d); mode = m; en = e;
    model(r, l, d, m, e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_count"}, int'(count), m_cnt);
    check({tag, "_busy"},  int'(busy),  int'(m_cnt != 0));
    check({tag, "_zero"},  int'(zero),  int'(m_cnt == 0));
    check({tag, "_done"},  int'(done),  int'(m_done));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = '0; mode = 1'b0; en = 1'b0;

    // rst, load, din, mode, en -> count, busy, zero, done
    add(1,0,0,0,0, 0,0,1,0);
    add(0,1,3,0,1, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,1, 0,0,1,1);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,1,5,0,0, 5,1,0,0);
    add(0,0,0,0,1, 4,1,0,0);
    add(0,0,0,0,0, 4,1,0,0);
    add(0,0,0,0,1, 3,1,0,0);
    add(0,0,0,0,0, 3,1,0,0);
    add(0,0,0,0,1, 2,1,0,0);
    add(0,0,0,0,0, 2,1,0,0);
    add(0,0,0,0,1, 1,1,0,0);
    add(0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,1, 0,0,1,1);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,1,0,0,1, 0,0,1,0);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,1,1,0,0, 1,1,0,0);
    add(0,1,9,0,1, 9,1,0,0);
    add(0,0,0,0,0, 9,1,0,0);
    add(0,1,7,0,1, 7,1,0,0);
    add(0,0,0,0,1, 6,1,0,0);
    add(1,0,0,0,1, 0,0,1,0);
    add(0,0,0,0,1, 0,0,1,0);
    add(0,1,1,0,0, 1,1,0,0);
    add(1,0,0,0,1, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    if (RELOAD_EN) begin
      add(0,1,2,1,1, 2,1,0,0);
      add(0,0,0,0,1, 1,1,0,0);
      add(0,0,0,0,1, 2,1,0,1);
      add(0,0,0,0,1, 1,1,0,0);
      add(0,0,0,0,1, 2,1,0,1);
      add(0,0,0,0,0, 2,1,0,0);
      add(0,1,0,0,0, 0,0,1,0);
    end

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].mode, vecs[i].en);
      check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].cnt));
      check($sformatf("vec%0d_busy", i),  int'(busy),  int'(vecs[i].busy));
      check($sformatf("vec%0d_zero", i),  int'(zero),  int'(vecs[i].zero));
      check($sformatf("vec%0d_done", i),  int'(done),  int'(vecs[i].done));
    end

    // Load 15 one-shot: exactly 15 enabled steps to done, bounded wait.
    begin
      int  n;
      bit  seen;
      n = 0;
      seen = 0;
      cycle(0, 1, 15, 0, 0);
      check("load15_count", int'(count), 15);
      for (int k = 0; k < 40 && !seen; k++) begin
        cycle(0, 0, 0, 0, 1);
        n++;
        if (done) seen = 1;
        else check($sformatf("load15_step%0d", n), int'(count), 15 - n);
      end
      check("load15_done_seen", int'(seen), 1);
      check("load15_steps", n, 15);
      check("load15_final_count", int'(count), 0);
      check("load15_final_busy", int'(busy), 0);
    end

    // Randomized stimulus against the reference model.
    for (int k = 0; k < 2000; k++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
